// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
//
// Purpose:
//   Pipeline MEM stage. It captures the execute-stage instruction into a
//   stage register, issues a data-memory request for loads/stores through a
//   three-state FSM (IDLE / REQ / WAIT_RSP), stalls upstream stages until the
//   access completes, aligns and extends load data, and registers the result
//   into a writeback register.
//
// Configuration:
//   MEM_MISALIGN_TRAP_EN - when defined, misaligned halfword/word accesses
//   issue no request, complete at once and pulse misalign_fault_o in the
//   writeback cycle without a register write. When undefined, the fault
//   output is tied 0 and the memory address is forced to the aligned address.
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-low reset
//   is_valid_i, flush_i         execute-stage valid / kill of the captured slot
//   mem_op_i, mem_size_i        00 none/01 load/10 store; 00 B/01 H/1x W
//   load_signed_i               sign-extend sub-word loads
//   reg_write_en_i, reg_dest_i  writeback intent and destination
//   alu_result_i, store_data_i  address (or ALU result) and store data
//   dmem_*_o / dmem_*_i         data-memory request, grant and read response
//   stall_o                     freeze upstream stages
//   reg_*_MEM_o                 MEM-stage forwarding source
//   wb_*_o                      writeback register
//   misalign_fault_o            misaligned-access fault pulse
//
// All outputs are forced to 0 while reset_i is low.
// ---------------------------------------------------------------------------
module memory_access_stage #(
    parameter int WORD       = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  is_valid_i,
    input  logic                  flush_i,
    input  logic [1:0]            mem_op_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  load_signed_i,
    input  logic                  reg_write_en_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_i,
    input  logic [WORD-1:0]       alu_result_i,
    input  logic [WORD-1:0]       store_data_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [WORD-1:0]       dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [WORD-1:0]       dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [WORD-1:0]       dmem_rdata_i,
    output logic                  stall_o,
    output logic                  reg_write_en_MEM_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_MEM_o,
    output logic [WORD-1:0]       reg_data_MEM_o,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_en_o,
    output logic [ADDR_WIDTH-1:0] wb_reg_dest_o,
    output logic [WORD-1:0]       wb_data_o,
    output logic                  misalign_fault_o
);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            op;
        logic [1:0]            size;
        logic                  sgn;
        logic                  we;
        logic [ADDR_WIDTH-1:0] dest;
        logic [WORD-1:0]       alu;
        logic [WORD-1:0]       sdata;
    } stage_t;

    stage_t                stage_q, stage_d;
    state_e                state_q, state_d;

    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_we_q, wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
    logic [WORD-1:0]       wb_data_q, wb_data_d;

    logic                  is_load_s;
    logic                  is_store_s;
    logic                  is_mem_s;
    logic                  misalign_s;
    logic [1:0]            offset_s;
    logic [3:0]            be_s;
    logic [WORD-1:0]       wdata_s;
    logic                  req_s;
    logic                  complete_s;
    logic                  stall_s;
    logic [7:0]            ld_byte_s;
    logic [15:0]           ld_half_s;
    logic [WORD-1:0]       load_data_s;

    // Decode the held operation: kind, alignment, lane offset, enables, write data.
    always_comb begin
        is_load_s  = stage_q.valid && (stage_q.op == OP_LOAD);
        is_store_s = stage_q.valid && (stage_q.op == OP_STORE);
        is_mem_s   = is_load_s || is_store_s;
        misalign_s = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (stage_q.size)
            SZ_BYTE: misalign_s = 1'b0;
            SZ_HALF: misalign_s = stage_q.alu[0];
            default: misalign_s = (stage_q.alu[1:0] != 2'b00);
        endcase
`endif
        // Lane offset of the aligned access; drives address low bits, enables and load shift.
        case (stage_q.size)
            SZ_BYTE: begin
                offset_s = stage_q.alu[1:0];
                be_s     = 4'b0001 << offset_s;
                wdata_s  = {4{stage_q.sdata[7:0]}};
            end
            SZ_HALF: begin
                offset_s = {stage_q.alu[1], 1'b0};
                be_s     = 4'b0011 << offset_s;
                wdata_s  = {2{stage_q.sdata[15:0]}};
            end
            default: begin
                offset_s = 2'b00;
                be_s     = 4'b1111;
                wdata_s  = stage_q.sdata;
            end
        endcase
    end

    // Memory FSM next state, request strobe and completion of the held access.
    always_comb begin
        state_d    = state_q;
        req_s      = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_s) begin
                    if (misalign_s) begin
                        complete_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        req_s = 1'b1;
                        if (dmem_gnt_i) begin
                            complete_s = is_store_s;
                            state_d    = is_store_s ? ST_IDLE : ST_WAIT_RSP;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                req_s = 1'b1;
                if (dmem_gnt_i) begin
                    complete_s = is_store_s;
                    state_d    = is_store_s ? ST_IDLE : ST_WAIT_RSP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT_RSP: begin
                // rvalid is only looked at here, never in the grant cycle.
                if (dmem_rvalid_i) begin
                    complete_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        stall_s = is_mem_s && !complete_s;
    end

    // Align the read response and extend it to the access size.
    always_comb begin
        ld_byte_s = dmem_rdata_i[{offset_s, 3'b000} +: 8];
        ld_half_s = dmem_rdata_i[{offset_s[1], 4'b0000} +: 16];
        case (stage_q.size)
            SZ_BYTE: begin
                if (stage_q.sgn) begin
                    load_data_s = {{24{ld_byte_s[7]}}, ld_byte_s};
                end else begin
                    load_data_s = {24'd0, ld_byte_s};
                end
            end
            SZ_HALF: begin
                if (stage_q.sgn) begin
                    load_data_s = {{16{ld_half_s[15]}}, ld_half_s};
                end else begin
                    load_data_s = {16'd0, ld_half_s};
                end
            end
            default: load_data_s = dmem_rdata_i;
        endcase
    end

    // Stage-register and writeback next state; a stalled stage holds and emits no writeback.
    always_comb begin
        stage_d = stage_q;
        if (!stall_s) begin
            if (flush_i || !is_valid_i) begin
                stage_d = '0;
            end else begin
                stage_d.valid = 1'b1;
                stage_d.op    = mem_op_i;
                stage_d.size  = mem_size_i;
                stage_d.sgn   = load_signed_i;
                stage_d.we    = reg_write_en_i;
                stage_d.dest  = reg_dest_i;
                stage_d.alu   = alu_result_i;
                stage_d.sdata = store_data_i;
            end
        end else begin
            stage_d = stage_q;
        end
        wb_valid_d = stage_q.valid && !stall_s;
        wb_we_d    = stage_q.valid && stage_q.we && !stall_s && !misalign_s;
        wb_dest_d  = stage_q.dest;
        if (is_load_s) begin
            wb_data_d = load_data_s;
        end else begin
            wb_data_d = stage_q.alu;
        end
    end

    // FSM state register; reset abandons any outstanding access.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage register; reset loads a bubble.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Writeback register.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_dest_q  <= {ADDR_WIDTH{1'b0}};
            wb_data_q  <= {WORD{1'b0}};
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic fault_q;

    // Fault pulse registered alongside the writeback of a trapped access.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= is_mem_s && misalign_s;
        end
    end

    assign misalign_fault_o = reset_i && fault_q;
`else
    assign misalign_fault_o = 1'b0;
`endif

    // Outputs are gated by reset so they read 0 while reset is held.
    assign dmem_req_o         = reset_i && req_s;
    assign dmem_we_o          = reset_i && req_s && is_store_s;
    assign dmem_addr_o        = (reset_i && req_s) ? {stage_q.alu[WORD-1:2], offset_s} : {WORD{1'b0}};
    assign dmem_be_o          = (reset_i && req_s) ? be_s : 4'b0000;
    assign dmem_wdata_o       = (reset_i && req_s && is_store_s) ? wdata_s : {WORD{1'b0}};
    assign stall_o            = reset_i && stall_s;
    assign reg_write_en_MEM_o = reset_i && stage_q.valid && stage_q.we && (stage_q.op != OP_LOAD);
    assign reg_dest_MEM_o     = reset_i ? stage_q.dest : {ADDR_WIDTH{1'b0}};
    assign reg_data_MEM_o     = reset_i ? stage_q.alu : {WORD{1'b0}};
    assign wb_valid_o         = reset_i && wb_valid_q;
    assign wb_reg_write_en_o  = reset_i && wb_we_q;
    assign wb_reg_dest_o      = reset_i ? wb_dest_q : {ADDR_WIDTH{1'b0}};
    assign wb_data_o          = reset_i ? wb_data_q : {WORD{1'b0}};

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        is_valid_i, flush_i, load_signed_i, reg_write_en_i;
    logic [1:0]  mem_op_i, mem_size_i;
    logic [3:0]  reg_dest_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, reg_write_en_MEM_o;
    logic [3:0]  reg_dest_MEM_o;
    logic [31:0] reg_data_MEM_o;
    logic        wb_valid_o, wb_reg_write_en_o;
    logic [3:0]  wb_reg_dest_o;
    logic [31:0] wb_data_o;
    logic        misalign_fault_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    memory_access_stage #(.WORD(32), .ADDR_WIDTH(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .is_valid_i(is_valid_i), .flush_i(flush_i),
        .mem_op_i(mem_op_i), .mem_size_i(mem_size_i),
        .load_signed_i(load_signed_i), .reg_write_en_i(reg_write_en_i),
        .reg_dest_i(reg_dest_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o),
        .reg_write_en_MEM_o(reg_write_en_MEM_o), .reg_dest_MEM_o(reg_dest_MEM_o),
        .reg_data_MEM_o(reg_data_MEM_o),
        .wb_valid_o(wb_valid_o), .wb_reg_write_en_o(wb_reg_write_en_o),
        .wb_reg_dest_o(wb_reg_dest_o), .wb_data_o(wb_data_o),
        .misalign_fault_o(misalign_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        is_valid_i     = 1'b0;
        flush_i        = 1'b0;
        mem_op_i       = 2'b00;
        mem_size_i     = 2'b00;
        load_signed_i  = 1'b0;
        reg_write_en_i = 1'b0;
        reg_dest_i     = 4'd0;
        alu_result_i   = 32'd0;
        store_data_i   = 32'd0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                         input logic we, input logic [3:0] dest,
                         input logic [31:0] alu, input logic [31:0] sd);
        is_valid_i     = 1'b1;
        flush_i        = 1'b0;
        mem_op_i       = op;
        mem_size_i     = sz;
        load_signed_i  = sgn;
        reg_write_en_i = we;
        reg_dest_i     = dest;
        alu_result_i   = alu;
        store_data_i   = sd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_req"}, 32'(dmem_req_o), 32'd0);
        chk({tag, "_addr"}, dmem_addr_o, 32'd0);
        chk({tag, "_fwd_we"}, 32'(reg_write_en_MEM_o), 32'd0);
        chk({tag, "_fwd_data"}, reg_data_MEM_o, 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        chk({tag, "_wb_we"}, 32'(wb_reg_write_en_o), 32'd0);
        chk({tag, "_wb_data"}, wb_data_o, 32'd0);
        chk({tag, "_fault"}, 32'(misalign_fault_o), 32'd0);
    endtask

    initial begin
        // Reset with a valid load presented: nothing may be captured or driven.
        reset_i       = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        drive(2'b01, 2'b10, 1'b0, 1'b1, 4'd1, 32'h0000_0040, 32'd0);
        @(negedge clk_i);
        chk_all_zero("reset");
        @(negedge clk_i);
        reset_i = 1'b1;
        idle_in();
        #1;
        chk("post_reset_stall", 32'(stall_o), 32'd0);
        chk("post_reset_req", 32'(dmem_req_o), 32'd0);

        // ALU op: forwarding from the stage, writeback one cycle later.
        @(negedge clk_i);
        drive(2'b00, 2'b00, 1'b0, 1'b1, 4'd5, 32'h1234_5678, 32'd0);
        @(negedge clk_i);
        chk("alu_fwd_we", 32'(reg_write_en_MEM_o), 32'd1);
        chk("alu_fwd_dest", 32'(reg_dest_MEM_o), 32'd5);
        chk("alu_fwd_data", reg_data_MEM_o, 32'h1234_5678);
        chk("alu_stall", 32'(stall_o), 32'd0);
        chk("alu_req", 32'(dmem_req_o), 32'd0);
        // Word store 0x100 = DEADBEEF behind it.
        drive(2'b10, 2'b10, 1'b0, 1'b0, 4'd0, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk_i);
        chk("alu_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("alu_wb_we", 32'(wb_reg_write_en_o), 32'd1);
        chk("alu_wb_dest", 32'(wb_reg_dest_o), 32'd5);
        chk("alu_wb_data", wb_data_o, 32'h1234_5678);
        idle_in();
        dmem_gnt_i = 1'b1;
        #1;
        chk("sw_req", 32'(dmem_req_o), 32'd1);
        chk("sw_we", 32'(dmem_we_o), 32'd1);
        chk("sw_be", 32'(dmem_be_o), 32'hF);
        chk("sw_addr", dmem_addr_o, 32'h0000_0100);
        chk("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
        chk("sw_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        chk("sw_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("sw_wb_we", 32'(wb_reg_write_en_o), 32'd0);
        chk("sw_after_stall", 32'(stall_o), 32'd0);
        chk("sw_after_req", 32'(dmem_req_o), 32'd0);

        // Byte store at 0x101 and halfword store at 0x6, both granted at once.
        drive(2'b10, 2'b00, 1'b0, 1'b0, 4'd0, 32'h0000_0101, 32'h0000_00AB);
        @(negedge clk_i);
        idle_in();
        dmem_gnt_i = 1'b1;
        #1;
        chk("sb_be", 32'(dmem_be_o), 32'h2);
        chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
        chk("sb_addr", dmem_addr_o, 32'h0000_0101);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        drive(2'b10, 2'b01, 1'b0, 1'b0, 4'd0, 32'h0000_0006, 32'h1234_BEEF);
        @(negedge clk_i);
        idle_in();
        dmem_gnt_i = 1'b1;
        #1;
        chk("sh_be", 32'(dmem_be_o), 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_addr_o, 32'h0000_0006);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;

        // Signed byte load 0x103, granted on the 3rd request cycle; an ALU op waits behind it.
        drive(2'b01, 2'b00, 1'b1, 1'b1, 4'd7, 32'h0000_0103, 32'd0);
        @(negedge clk_i);
        drive(2'b00, 2'b00, 1'b0, 1'b1, 4'd9, 32'h0000_0055, 32'd0);
        #1;
        chk("lb_c1_stall", 32'(stall_o), 32'd1);
        chk("lb_c1_req", 32'(dmem_req_o), 32'd1);
        chk("lb_c1_be", 32'(dmem_be_o), 32'h8);
        chk("lb_c1_addr", dmem_addr_o, 32'h0000_0103);
        chk("lb_c1_we", 32'(dmem_we_o), 32'd0);
        chk("lb_fwd_we", 32'(reg_write_en_MEM_o), 32'd0);
        @(negedge clk_i);
        chk("lb_c2_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("lb_c2_stall", 32'(stall_o), 32'd1);
        chk("lb_c2_req", 32'(dmem_req_o), 32'd1);
        chk("lb_c2_addr", dmem_addr_o, 32'h0000_0103);
        @(negedge clk_i);
        dmem_gnt_i = 1'b1;
        #1;
        chk("lb_c3_stall", 32'(stall_o), 32'd1);
        chk("lb_c3_req", 32'(dmem_req_o), 32'd1);
        @(negedge clk_i);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80FF_FFFF;
        #1;
        chk("lb_rsp_stall", 32'(stall_o), 32'd0);
        chk("lb_rsp_req", 32'(dmem_req_o), 32'd0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk("lb_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("lb_wb_we", 32'(wb_reg_write_en_o), 32'd1);
        chk("lb_wb_dest", 32'(wb_reg_dest_o), 32'd7);
        chk("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
        chk("held_alu_fwd_dest", 32'(reg_dest_MEM_o), 32'd9);
        chk("held_alu_fwd_data", reg_data_MEM_o, 32'h0000_0055);
        // Unsigned halfword load from 0x2.
        drive(2'b01, 2'b01, 1'b0, 1'b1, 4'd3, 32'h0000_0002, 32'd0);
        @(negedge clk_i);
        chk("held_alu_wb_data", wb_data_o, 32'h0000_0055);
        idle_in();
        dmem_gnt_i = 1'b1;
        #1;
        chk("lhu_be", 32'(dmem_be_o), 32'hC);
        chk("lhu_addr", dmem_addr_o, 32'h0000_0002);
        chk("lhu_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h8001_AAAA;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk("lhu_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("lhu_wb_data", wb_data_o, 32'h0000_8001);

        // Flush while a word load waits for its response.
        drive(2'b01, 2'b10, 1'b0, 1'b1, 4'd4, 32'h0000_0040, 32'd0);
        @(negedge clk_i);
        idle_in();
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b1, 4'd6, 32'h0000_0077, 32'd0);
        flush_i = 1'b1;
        #1;
        chk("flush_wait_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        #1;
        chk("flush_rsp_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        idle_in();
        chk("flush_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("flush_wb_we", 32'(wb_reg_write_en_o), 32'd1);
        chk("flush_wb_dest", 32'(wb_reg_dest_o), 32'd4);
        chk("flush_wb_data", wb_data_o, 32'hCAFE_F00D);
        chk("flush_bubble_fwd_we", 32'(reg_write_en_MEM_o), 32'd0);
        @(negedge clk_i);
        chk("flush_bubble_wb_valid", 32'(wb_valid_o), 32'd0);

        // Misaligned word load from 0x102.
        drive(2'b01, 2'b10, 1'b0, 1'b1, 4'd2, 32'h0000_0102, 32'd0);
        @(negedge clk_i);
        idle_in();
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        chk("mis_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        chk("mis_fault", 32'(misalign_fault_o), 32'd1);
        chk("mis_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("mis_wb_we", 32'(wb_reg_write_en_o), 32'd0);
        @(negedge clk_i);
        chk("mis_fault_pulse", 32'(misalign_fault_o), 32'd0);
`else
        dmem_gnt_i = 1'b1;
        #1;
        chk("mis_req", 32'(dmem_req_o), 32'd1);
        chk("mis_addr", dmem_addr_o, 32'h0000_0100);
        chk("mis_be", 32'(dmem_be_o), 32'hF);
        @(negedge clk_i);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1122_3344;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk("mis_wb_data", wb_data_o, 32'h1122_3344);
        chk("mis_wb_we", 32'(wb_reg_write_en_o), 32'd1);
        chk("mis_fault", 32'(misalign_fault_o), 32'd0);
`endif

        // Reset while waiting for a response; a late rvalid must be ignored.
        drive(2'b01, 2'b10, 1'b0, 1'b1, 4'd8, 32'h0000_0200, 32'd0);
        @(negedge clk_i);
        idle_in();
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        reset_i    = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk_i);
        reset_i       = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_0000;
        #1;
        chk("rst_late_stall", 32'(stall_o), 32'd0);
        chk("rst_late_req", 32'(dmem_req_o), 32'd0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk("rst_late_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_late_wb_we", 32'(wb_reg_write_en_o), 32'd0);
        chk("rst_late_wb_data", wb_data_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Parameter WORD, 32, datapath width in bits; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, 4, register-file address width.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, synchronous, active-low.
REQ-005 is_valid_i  in  1  execute-stage instruction is valid.
REQ-006 flush_i  in  1  kill the execute-stage instruction being captured this cycle.
REQ-007 mem_op_i  in  2  00 none, 01 load, 10 store, 11 treated as none.
REQ-008 mem_size_i  in  2  00 byte, 01 halfword, 10/11 word.
REQ-009 load_signed_i  in  1  sign-extend loaded byte/halfword.
REQ-010 reg_write_en_i  in  1 / reg_dest_i  in  ADDR_WIDTH  writeback intent and destination.
REQ-011 alu_result_i  in  WORD  ALU result; this is the memory address for loads and stores.
REQ-012 store_data_i  in  WORD  forwarded store data from execute.
REQ-013 dmem_req_o out 1, dmem_we_o out 1, dmem_addr_o out WORD, dmem_be_o out 4, dmem_wdata_o out WORD  data-memory request.
REQ-014 dmem_gnt_i in 1, dmem_rvalid_i in 1, dmem_rdata_i in WORD  data-memory grant and read response.
REQ-015 stall_o  out  1  freeze all upstream stages.
REQ-016 reg_write_en_MEM_o out 1, reg_dest_MEM_o out ADDR_WIDTH, reg_data_MEM_o out WORD  MEM-stage forwarding source.
REQ-017 wb_valid_o out 1, wb_reg_write_en_o out 1, wb_reg_dest_o out ADDR_WIDTH, wb_data_o out WORD  writeback register.
REQ-018 misalign_fault_o  out  1  misaligned-access fault pulse.

Function
REQ-019 The stage register SHALL capture all execute inputs on each edge where stall_o=0, and SHALL hold its contents while stall_o=1.
REQ-020 A capture with flush_i=1 or is_valid_i=0 SHALL load a bubble (valid=0, mem_op=none, reg_write_en=0).
REQ-021 flush_i SHALL NOT cancel an operation already held in the stage register.
REQ-022 Forwarding outputs SHALL come from the stage register: reg_data_MEM_o=alu_result; reg_write_en_MEM_o=valid AND reg_write_en AND mem_op!=load.
REQ-023 The FSM SHALL have the states IDLE, REQ and WAIT_RSP.
REQ-024 In IDLE, when the stage holds a valid load or store, dmem_req_o SHALL assert combinationally in the same cycle.
REQ-025 A request accepted by dmem_gnt_i=1 SHALL complete a store in that cycle, and SHALL move a load to WAIT_RSP.
REQ-026 A request not granted SHALL move the FSM to REQ, with the address, byte-enable, write-data and write-enable outputs held stable until granted.
REQ-027 The FSM SHALL leave WAIT_RSP on dmem_rvalid_i=1; rvalid is never sampled in the grant cycle.
REQ-028 stall_o SHALL equal (stage holds a valid memory op) AND NOT (completion this cycle).
REQ-029 stall_o SHALL be 0 for non-memory ops and bubbles.
REQ-030 Byte-enable encoding:
- byte: dmem_be_o = 0001 << addr[1:0], wdata = byte replicated x4;
- half: dmem_be_o = 0011 << {addr[1],0}, wdata = half replicated x2;
- word: dmem_be_o = 1111.
REQ-031 Load data SHALL be dmem_rdata_i >> (8*addr[1:0]), truncated to the access size, then zero- or sign-extended per load_signed_i.
REQ-032 The writeback register SHALL update one cycle after completion, or one cycle after a non-memory op leaves the stage.
- wb_data_o = load data for loads, alu_result otherwise.
- wb_valid_o=0 on bubbles and on stalled cycles.
REQ-033 The full-throughput latency SHALL be 1 cycle, capture to writeback register, for non-memory ops and for stores granted immediately.

Reset
REQ-034 While reset_i=0 at an edge: FSM=IDLE, stage register=bubble, writeback register cleared.
REQ-035 All outputs SHALL be 0 while in reset, including stall_o and dmem_req_o.
REQ-036 Reset during REQ or WAIT_RSP SHALL abandon the access, and any later dmem_rvalid_i SHALL be ignored until a new load is granted.

Configuration
REQ-037 Macro MEM_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL issue no request and SHALL complete immediately.
- In that case misalign_fault_o SHALL pulse 1 in the writeback cycle, with wb_reg_write_en_o=0.
- Undefined: misalign_fault_o SHALL be tied 0, and dmem_addr_o low bits SHALL be forced to the aligned address.

Verification
REQ-038 Word store to 0x100 of 0xDEADBEEF, gnt same cycle -> req=1, we=1, be=1111, stall_o=0 throughout.
REQ-039 Signed byte load from 0x103, gnt after 2 cycles, rdata=0x80FFFFFF one cycle later -> stall_o=1 for 3 cycles, wb_data_o=0xFFFFFF80.
REQ-040 Unsigned halfword load from 0x2, rdata=0x8001AAAA -> wb_data_o=0x00008001, be=1100.
REQ-041 flush_i asserted while a load is stalled in WAIT_RSP -> the load still writes back; next captured slot is a bubble.
REQ-042 Word load from 0x102 -> with macro: no dmem_req_o, misalign_fault_o=1 pulse, no writeback; without macro: dmem_addr_o=0x100.
REQ-043 reset_i=0 during WAIT_RSP, then rvalid arrives -> no writeback; all outputs 0.
